tx_arbiter: RTL and testbench
=============================

Name: tx_arbiter

Overview:
- Round-robin scheduler sharing one serial transmitter (9-bit frame: 8 data + parity) between NUM_REQ byte sources.
- Selects a requester, hands its byte to the transmitter with a one-cycle start strobe, and waits for the transmitter's done pulse.
- Enforces an inter-frame gap before the next grant.
- Sits between the link-layer producers and the transmitter; the receiver side is unaffected.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, payload width per requester; parity is added by the transmitter.
- GAP_CYCLES, 2, idle cycles between tx_done and the next grant (0 allowed).
- TIMEOUT, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- arst  in  1  asynchronous reset, active-low.
- req  in  NUM_REQ  per-requester request, level.
- data_i  in  NUM_REQ*DATA_W  packed payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- ack  out  NUM_REQ  one-hot, one-cycle pulse: payload accepted.
- tx_start  out  1  one-cycle strobe to the transmitter.
- tx_data  out  DATA_W  registered payload, stable from tx_start until tx_done.
- tx_done  in  1  one-cycle pulse from the transmitter: frame sent.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last winner.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle watchdog abort pulse; tied 0 when the feature is absent.

Behaviour:
- Reset (arst low, asynchronous): state=IDLE; ack, tx_start, tx_data, busy, err all 0; grant_id=0; rr pointer=0 so requester 0 has top priority first.
- Deassertion is used synchronously.
- States:
  - IDLE: if any req bit is set at edge k, pick the first set bit searching from ptr upward with wrap (ptr, ptr+1, ..., NUM_REQ-1, 0, ...). Register tx_data=data_i[winner], grant_id=winner, ptr=winner+1 mod NUM_REQ; go to START. No req keeps the FSM in IDLE.
  - START: ack[grant_id]=1 and tx_start=1 for exactly this cycle; go to WAIT. Latency is req sampled at edge k, then tx_start/ack high during the cycle after edge k.
  - WAIT: hold tx_data. On tx_done go to GAP, or straight to IDLE if GAP_CYCLES=0. A tx_done outside WAIT is ignored.
  - GAP: count GAP_CYCLES cycles, then go to IDLE. Requests are not sampled during the gap.
- Requester rules:
  - Must hold req and data_i stable until ack.
  - May drop req before ack to withdraw; sampling happens only in IDLE, so this is safe.
  - Must drop or renew req the cycle after ack; a req still high is treated as a new request.
- Fairness: a requester that keeps req high is served at most once per NUM_REQ grants while others are pending.
- Simultaneous events:
  - tx_done in the same cycle as new req edges: the done is consumed first; the new req is served after the gap.
  - All req high: grants go strictly 0,1,2,3,0,...
- Throughput: next tx_start is at the earliest GAP_CYCLES+2 cycles after the tx_done cycle.
- Reset mid-frame: abort immediately and return to the reset values. The transmitter is reset by the same arst.

Optional Feature:
- Macro TX_ARB_WATCHDOG_EN.
- Defined:
  - A counter runs in WAIT. If it reaches TIMEOUT cycles without tx_done, pulse err for one cycle, move to GAP, and keep the pointer already advanced (the lost byte is not retried).
  - The counter clears on entry to WAIT.
- Undefined: no counter; WAIT lasts indefinitely; err is driven constant 0.

Decomposition:
- Shared package tx_pkg: state enum/localparams (IDLE, START, WAIT, GAP), FRAME_W=9, default DATA_W.
- One sub-module rr_pick: combinational round-robin priority encoder (req, ptr -> valid, winner index). The FSM, counters and registers stay in tx_arbiter.

Test Plan:
- Reset: hold arst low for 3 cycles with req=4'b1111 -> all outputs 0; after release, first tx_start carries data_i[0]=8'hA5, grant_id=0, ack=4'b0001.
- All requests held: req=4'b1111, tx_done returned 5 cycles after each tx_start -> grant order 0,1,2,3,0; consecutive tx_start exactly GAP_CYCLES+2 cycles after each tx_done.
- Sparse/withdraw: req=4'b0100, drop req[2] during WAIT of an earlier grant -> requester 2 never acked; req[3]=1 with data 8'h3C -> ack=4'b1000, tx_data=8'h3C stable until tx_done.
- GAP_CYCLES=0 build: tx_done and req[1] in the same cycle -> next tx_start one cycle after IDLE; tx_done asserted in IDLE is ignored (busy stays 0).
- Mid-frame reset: assert arst in WAIT -> tx_data, busy, grant_id go to 0 without waiting for a clock edge; the next grant starts again from requester 0.
- With TX_ARB_WATCHDOG_EN and TIMEOUT=64, no tx_done -> err pulses on cycle 64 of WAIT, FSM passes through GAP, next grant goes to requester ptr (not the same requester again).

Source files
------------

// File: rtl/tx_pkg.sv
// tx_pkg: shared FSM state encoding and frame constants for the transmit arbiter.
package tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        GAP
    } state_t;

    localparam int FRAME_W    = 9;
    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder; first set request at or after ptr, with wrap.
module rr_pick
    import tx_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic               valid_o,
    output logic [PW-1:0]      winner_o
);

    // Scan from the farthest offset down so the nearest offset to ptr is written last and wins.
    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[(int'(ptr_i) + i) % NUM_REQ]) begin
                valid_o  = 1'b1;
                winner_o = PW'((int'(ptr_i) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin scheduler sharing one serial transmitter between NUM_REQ byte sources.
// Optional TX_ARB_WATCHDOG_EN adds a WAIT-state watchdog that aborts a frame and pulses err.
module tx_arbiter
    import tx_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  data_i,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       err
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam state_t AFTER_TX = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       grant_q, grant_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [PW-1:0]       win;
    logic                valid;
    logic                timeout;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .valid_o  (valid),
        .winner_o (win)
    );

`ifdef TX_ARB_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wd_q, wd_d;
    // Counter is zero in every other state, so it restarts on each entry to WAIT.
    assign wd_d    = (state_q == WAIT) ? wd_q + 1'b1 : '0;
    assign timeout = (state_q == WAIT) && !tx_done && (wd_q == WW'(TIMEOUT - 1));
    assign err     = timeout;
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) wd_q <= '0;
        else       wd_q <= wd_d;
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: if (valid) begin
                state_d = START;
                grant_d = win;
                data_d  = data_i[win*DATA_W +: DATA_W];
                ptr_d   = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            end
            START: state_d = WAIT;
            WAIT: if (tx_done || timeout) begin
                state_d = AFTER_TX;
                gap_d   = '0;
            end
            GAP: begin
                state_d = (gap_q == GAP_LAST) ? IDLE : GAP;
                gap_d   = gap_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            gap_q   <= gap_d;
        end
    end

    assign tx_start = (state_q == START);
    assign ack      = tx_start ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q) : '0;
    assign busy     = (state_q != IDLE);
    assign tx_data  = data_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed self-checking bench; a second instance covers the zero-gap build.
module tb_tx_arbiter;

    logic        clk = 1'b0;
    logic        arst = 1'b0;
    logic [3:0]  req = '0, req0 = '0;
    logic [31:0] data_i = {8'h3C, 8'h22, 8'h11, 8'hA5};
    logic        tx_done = 1'b0, tx_done0 = 1'b0;
    logic [3:0]  ack, ack0;
    logic        tx_start, tx_start0, busy, busy0, err, err0;
    logic [7:0]  tx_data, tx_data0;
    logic [1:0]  grant_id, grant0;
    int          checks = 0;
    int          fails = 0;

    tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(2), .TIMEOUT(64)) dut (
        .clk(clk), .arst(arst), .req(req), .data_i(data_i), .ack(ack), .tx_start(tx_start),
        .tx_data(tx_data), .tx_done(tx_done), .grant_id(grant_id), .busy(busy), .err(err)
    );

    tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(0), .TIMEOUT(64)) dut0 (
        .clk(clk), .arst(arst), .req(req0), .data_i(data_i), .ack(ack0), .tx_start(tx_start0),
        .tx_data(tx_data0), .tx_done(tx_done0), .grant_id(grant0), .busy(busy0), .err(err0)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        arst = 1'b0;
        req  = 4'b1111;
        repeat (3) tick;
        checks++; if (ack !== 4'b0 || tx_start !== 1'b0) begin fails++; $display("FAIL reset_strobes ack=%b tx_start=%b want 0", ack, tx_start); end
        checks++; if (tx_data !== 8'h00 || grant_id !== 2'd0) begin fails++; $display("FAIL reset_regs tx_data=%h grant_id=%0d want 0", tx_data, grant_id); end
        checks++; if (busy !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL reset_flags busy=%b err=%b want 0", busy, err); end
        arst = 1'b1;
        tick;
        checks++; if (tx_start !== 1'b1 || ack !== 4'b0001) begin fails++; $display("FAIL first_grant tx_start=%b ack=%b want 1 0001", tx_start, ack); end
        checks++; if (tx_data !== 8'hA5 || grant_id !== 2'd0) begin fails++; $display("FAIL first_data tx_data=%h grant_id=%0d want a5 0", tx_data, grant_id); end
    endtask

    // Waits for tx_start, checks the grant, holds WAIT, returns tx_done 5 cycles after tx_start.
    // lat is the expected tx_done-cycle to tx_start distance (<=0 skips that check).
    task automatic serve(input int id, input logic [7:0] d, input int lat, input logic [3:0] req_after);
        int n = 0;
        while (tx_start !== 1'b1 && n < 40) begin tick; n++; end
        checks++; if (n == 40) begin fails++; $display("FAIL serve_timeout id=%0d no tx_start within 40 cycles", id); return; end
        if (lat > 0) begin
            checks++; if (n + 1 != lat) begin fails++; $display("FAIL serve_spacing id=%0d got %0d want %0d", id, n + 1, lat); end
        end
        checks++; if (grant_id !== 2'(id) || ack !== (4'b0001 << id)) begin fails++; $display("FAIL serve_grant grant_id=%0d ack=%b want %0d", grant_id, ack, id); end
        checks++; if (tx_data !== d) begin fails++; $display("FAIL serve_data tx_data=%h want %h", tx_data, d); end
        tick;
        req = req_after;
        repeat (4) begin
            checks++; if (tx_data !== d || busy !== 1'b1 || ack !== 4'b0) begin fails++; $display("FAIL serve_hold tx_data=%h busy=%b ack=%b want %h 1 0", tx_data, busy, ack, d); end
            tick;
        end
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
    endtask

    task automatic test_all_req;
        serve(0, 8'hA5, -1, 4'hF);
        serve(1, 8'h11, 4, 4'hF);
        serve(2, 8'h22, 4, 4'hF);
        serve(3, 8'h3C, 4, 4'hF);
        serve(0, 8'hA5, 4, 4'hF);
    endtask

    task automatic test_withdraw;
        req = 4'b0110;
        serve(1, 8'h11, 4, 4'b1000);
        serve(3, 8'h3C, 4, 4'b0000);
        repeat (3) tick;
        checks++; if (busy !== 1'b0 || ack !== 4'b0) begin fails++; $display("FAIL withdraw_idle busy=%b ack=%b want 0 0", busy, ack); end
    endtask

    task automatic test_mid_reset;
        int n = 0;
        req = 4'b0010;
        while (tx_start !== 1'b1 && n < 40) begin tick; n++; end
        checks++; if (grant_id !== 2'd1) begin fails++; $display("FAIL pre_reset_grant grant_id=%0d want 1", grant_id); end
        tick;
        req = 4'b0101;
        #2 arst = 1'b0;
        #1;
        checks++; if (tx_data !== 8'h00 || busy !== 1'b0 || grant_id !== 2'd0) begin fails++; $display("FAIL async_reset tx_data=%h busy=%b grant_id=%0d want 0", tx_data, busy, grant_id); end
        tick;
        arst = 1'b1;
        tick;
        checks++; if (tx_start !== 1'b1 || grant_id !== 2'd0 || tx_data !== 8'hA5) begin fails++; $display("FAIL post_reset_grant tx_start=%b grant_id=%0d tx_data=%h want 1 0 a5", tx_start, grant_id, tx_data); end
        req = 4'b0000;
        repeat (3) tick;
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
        repeat (3) tick;
    endtask

    task automatic test_gap0;
        int n = 0;
        tx_done0 = 1'b1;
        tick;
        tx_done0 = 1'b0;
        checks++; if (busy0 !== 1'b0 || tx_start0 !== 1'b0) begin fails++; $display("FAIL idle_done busy=%b tx_start=%b want 0 0", busy0, tx_start0); end
        req0 = 4'b0010;
        while (tx_start0 !== 1'b1 && n < 40) begin tick; n++; end
        checks++; if (grant0 !== 2'd1 || ack0 !== 4'b0010) begin fails++; $display("FAIL gap0_grant grant_id=%0d ack=%b want 1 0010", grant0, ack0); end
        tick;
        req0 = 4'b0000;
        repeat (2) tick;
        tx_done0 = 1'b1;
        req0 = 4'b0010;
        tick;
        tx_done0 = 1'b0;
        checks++; if (busy0 !== 1'b0 || tx_start0 !== 1'b0) begin fails++; $display("FAIL gap0_idle busy=%b tx_start=%b want 0 0", busy0, tx_start0); end
        tick;
        checks++; if (tx_start0 !== 1'b1 || grant0 !== 2'd1 || tx_data0 !== 8'h11) begin fails++; $display("FAIL gap0_restart tx_start=%b grant_id=%0d tx_data=%h want 1 1 11", tx_start0, grant0, tx_data0); end
        req0 = 4'b0000;
        tick;
        tx_done0 = 1'b1;
        tick;
        tx_done0 = 1'b0;
        tick;
        checks++; if (busy0 !== 1'b0 || err0 !== 1'b0) begin fails++; $display("FAIL gap0_end busy=%b err=%b want 0 0", busy0, err0); end
    endtask

    task automatic test_watchdog;
        int n = 0;
        req = 4'b0010;
        while (tx_start !== 1'b1 && n < 40) begin tick; n++; end
        checks++; if (grant_id !== 2'd1) begin fails++; $display("FAIL wd_grant grant_id=%0d want 1", grant_id); end
        tick;
`ifdef TX_ARB_WATCHDOG_EN
        req = 4'b0110;
        for (int i = 1; i <= 64; i++) begin
            checks++; if (err !== (i == 64)) begin fails++; $display("FAIL wd_err cycle=%0d err=%b want %b", i, err, i == 64); end
            tick;
        end
        checks++; if (err !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL wd_gap err=%b busy=%b want 0 1", err, busy); end
        n = 0;
        while (tx_start !== 1'b1 && n < 40) begin tick; n++; end
        checks++; if (n != 3 || grant_id !== 2'd2) begin fails++; $display("FAIL wd_next wait=%0d grant_id=%0d want 3 2", n, grant_id); end
`else
        req = 4'b0000;
        for (int i = 1; i <= 70; i++) begin
            checks++; if (err !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL wd_absent cycle=%0d err=%b busy=%b want 0 1", i, err, busy); end
            tick;
        end
`endif
        req = 4'b0000;
        repeat (3) tick;
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
        repeat (3) tick;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL wd_end busy=%b want 0", busy); end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_all_req;
        test_withdraw;
        test_mid_reset;
        test_gap0;
        test_watchdog;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
